// File: rtl/layered_display_mux.sv
// Layered display mux: background plus prioritised sprite layers, blink,
// blank-on-state-change FSM, two-stage registered pipeline.
module layered_display_mux #(
  parameter int          NUM_OBJ      = 4,
  parameter int          ADDR_W       = 17,
  parameter int          BG_W         = 320,
  parameter int          BG_SIZE      = 76800,
  parameter int          SCALE        = 1,
  parameter int          BLANK_FRAMES = 2,
  parameter logic [14:0] BLINK_MASK   = '0,
  parameter int          BLINK_SHIFT  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                state,
  input  logic [9:0]                h_cnt,
  input  logic [9:0]                v_cnt,
  input  logic [NUM_OBJ-1:0]        obj_hit,
  input  logic [NUM_OBJ*ADDR_W-1:0] obj_addr,
  output logic [ADDR_W-1:0]         pixel_addr,
  output logic [3:0]                pixel_src,
  output logic                      blank
);

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } fsm_e;

  localparam fsm_e       FSM_RST = (BLANK_FRAMES > 0) ? BLANK : SHOW;
  localparam logic [7:0] BF      = 8'(BLANK_FRAMES);

  logic [3:0]                state_q;
  logic [9:0]                h1_q;
  logic [9:0]                v1_q;
  logic [NUM_OBJ-1:0]        hit1_q;
  logic [NUM_OBJ*ADDR_W-1:0] addr1_q;
  logic                      fs1_q;
  logic                      chg1_q;
  logic                      en1_q;

  fsm_e                      fsm_q, fsm_d;
  logic [7:0]                bcnt_q, bcnt_d;
  logic [7:0]                fcnt_q, fcnt_d;
  logic [NUM_OBJ-1:0]        vis;
  logic [31:0]               bg_full;
  logic [ADDR_W-1:0]         addr_d;
  logic [3:0]                src_d;
  logic                      blank_d;

  // Stage 1: capture the pixel and the events it observes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= state;
      h1_q    <= '0;
      v1_q    <= '0;
      hit1_q  <= '0;
      addr1_q <= '0;
      fs1_q   <= 1'b0;
      chg1_q  <= 1'b0;
      en1_q   <= 1'b0;
    end else begin
      state_q <= state;
      h1_q    <= h_cnt;
      v1_q    <= v_cnt;
      hit1_q  <= obj_hit;
      addr1_q <= obj_addr;
      fs1_q   <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
      chg1_q  <= (state != state_q);
      en1_q   <= (state == 4'd2) || (state == 4'd4) ||
                 (state == 4'd6);
    end
  end

  always_comb begin
    fcnt_d = fcnt_q + {7'd0, fs1_q};
    fsm_d  = fsm_q;
    bcnt_d = bcnt_q;
    unique case (fsm_q)
      SHOW: begin
        if (chg1_q && (BLANK_FRAMES > 0)) begin
          fsm_d  = BLANK;
          bcnt_d = BF;
        end
      end
      BLANK: begin
        // a state change reloads even on a frame start
        if (chg1_q) begin
          bcnt_d = BF;
        end else if (fs1_q) begin
          if (bcnt_q == 8'd1) fsm_d = SHOW;
          bcnt_d = bcnt_q - 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_OBJ; i++) begin
      vis[i] = en1_q && hit1_q[i] &&
               (!BLINK_MASK[i] || !fcnt_d[BLINK_SHIFT]);
    end
    bg_full = (32'(h1_q) >> SCALE) +
              32'(BG_W) * (32'(v1_q) >> SCALE);
    addr_d  = ADDR_W'(bg_full % 32'(BG_SIZE));
    src_d   = 4'd0;
    blank_d = 1'b0;
    // descending scan so the lowest visible index wins
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (vis[i]) begin
        addr_d = addr1_q[i*ADDR_W +: ADDR_W];
        src_d  = 4'(i + 1);
      end
    end
    if ((fsm_d == BLANK) || (h1_q >= 10'd640) ||
        (v1_q >= 10'd480)) begin
      addr_d  = '0;
      src_d   = 4'd15;
      blank_d = 1'b1;
    end
  end

  // Stage 2: FSM, frame counter and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= FSM_RST;
      bcnt_q     <= BF;
      fcnt_q     <= 8'd0;
      pixel_addr <= '0;
      pixel_src  <= 4'd15;
      blank      <= 1'b1;
    end else begin
      fsm_q      <= fsm_d;
      bcnt_q     <= bcnt_d;
      fcnt_q     <= fcnt_d;
      pixel_addr <= addr_d;
      pixel_src  <= src_d;
      blank      <= blank_d;
    end
  end

endmodule

// File: tb/tb_layered_display_mux.sv
// Bench for layered_display_mux: per-pixel reference model checked
// two cycles later, plus hand-computed pinned expectations.
module tb_layered_display_mux;

  localparam int          NOBJ = 4;
  localparam int          AW   = 17;
  localparam int          BF   = 2;
  localparam logic [14:0] BM   = 15'h1;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        state;
  logic [9:0]        h_cnt;
  logic [9:0]        v_cnt;
  logic [NOBJ-1:0]   obj_hit;
  logic [NOBJ*AW-1:0] obj_addr;
  logic [AW-1:0]     pixel_addr;
  logic [3:0]        pixel_src;
  logic              blank;

  always #5 clk = ~clk;

  layered_display_mux #(
    .NUM_OBJ(NOBJ),
    .ADDR_W(AW),
    .BLANK_FRAMES(BF),
    .BLINK_MASK(BM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .state(state),
    .h_cnt(h_cnt),
    .v_cnt(v_cnt),
    .obj_hit(obj_hit),
    .obj_addr(obj_addr),
    .pixel_addr(pixel_addr),
    .pixel_src(pixel_src),
    .blank(blank)
  );

  typedef struct {
    bit v;
    int a;
    int s;
    int b;
    bit lv;
    int la;
    int ls;
    int lb;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  exp_t        p0, p1;
  string       n0, n1;
  int          m_prev, m_fc, m_rem;
  logic [16:0] oa [4];

  task automatic check(input exp_t e, input string nm);
    if (e.v) begin
      tests++;
      if (pixel_addr !== 17'(e.a) || pixel_src !== 4'(e.s) ||
          blank !== e.b[0]) begin
        fails++;
        $display("FAIL model %s: got addr=%0d src=%0d blank=%0d, want addr=%0d src=%0d blank=%0d",
                 nm, pixel_addr, pixel_src, blank, e.a, e.s, e.b);
      end
    end
    if (e.lv) begin
      tests++;
      if (pixel_addr !== 17'(e.la) || pixel_src !== 4'(e.ls) ||
          blank !== e.lb[0]) begin
        fails++;
        $display("FAIL pin %s: got addr=%0d src=%0d blank=%0d, want addr=%0d src=%0d blank=%0d",
                 nm, pixel_addr, pixel_src, blank, e.la, e.ls, e.lb);
      end
    end
  endtask

  // One pixel per clock: check the pixel from two cycles ago, drive a new one
  task automatic step(input bit r, input int st, input int h,
                      input int v, input logic [3:0] hit);
    exp_t e;
    bit   fs;
    bit   found;
    @(negedge clk);
    check(p1, n1);
    p1 = p0;
    n1 = n0;
    rst     = r;
    state   = st[3:0];
    h_cnt   = h[9:0];
    v_cnt   = v[9:0];
    obj_hit = hit;
    for (int i = 0; i < NOBJ; i++) obj_addr[i*AW +: AW] = oa[i];
    e = '{default: 0};
    e.v = 1'b1;
    if (r) begin
      m_prev = st;
      m_fc   = 0;
      m_rem  = BF;
      e.a = 0;
      e.s = 15;
      e.b = 1;
      p1 = e;
      n1 = "reset";
      n0 = "reset";
    end else begin
      fs = (h == 0) && (v == 0);
      if (fs) m_fc = (m_fc + 1) % 256;
      if (st != m_prev && BF > 0) m_rem = BF;
      else if (fs && m_rem > 0) m_rem = m_rem - 1;
      m_prev = st;
      n0 = $sformatf("px(%0d,%0d,st%0d)", h, v, st);
      if (m_rem > 0 || h >= 640 || v >= 480) begin
        e.a = 0;
        e.s = 15;
        e.b = 1;
      end else begin
        e.a = ((h / 2) + 320 * (v / 2)) % 76800;
        e.s = 0;
        e.b = 0;
        found = 1'b0;
        if (st == 2 || st == 4 || st == 6) begin
          for (int i = 0; i < NOBJ; i++) begin
            if (!found && hit[i] &&
                (!BM[i] || ((m_fc / 16) % 2) == 0)) begin
              found = 1'b1;
              e.a = int'(oa[i]);
              e.s = i + 1;
            end
          end
        end
      end
    end
    p0 = e;
  endtask

  task automatic pin(input string nm, input int a, input int s,
                     input int b);
    p0.lv = 1'b1;
    p0.la = a;
    p0.ls = s;
    p0.lb = b;
    n0 = nm;
  endtask

  initial begin
    rst      = 1'b1;
    state    = 4'd0;
    h_cnt    = 10'd5;
    v_cnt    = 10'd5;
    obj_hit  = '0;
    obj_addr = '0;
    p0 = '{default: 0};
    p1 = '{default: 0};
    n0 = "";
    n1 = "";
    m_prev = 0;
    m_fc = 0;
    m_rem = BF;
    for (int i = 0; i < 4; i++) oa[i] = '0;

    repeat (3) step(1, 0, 5, 5, 4'b0000);

    // partial frame, one full frame, then the third frame shows
    step(0, 0, 10, 0, 4'b0000);
    step(0, 0, 11, 0, 4'b0000);
    step(0, 0, 0, 0, 4'b0000);
    step(0, 0, 12, 3, 4'b0000);
    pin("t1_frame2", 0, 15, 1);
    step(0, 0, 0, 0, 4'b0000);
    pin("t1_frame3", 0, 0, 0);

    oa[0] = 17'd77;
    oa[1] = 17'd500;
    oa[2] = 17'd900;
    oa[3] = 17'd1234;

    // blink of layer 0 over frame counts 4..33
    step(0, 2, 3, 0, 4'b0000);
    pin("chg_blank", 0, 15, 1);
    step(0, 2, 0, 0, 4'b0000);
    step(0, 2, 5, 5, 4'b0001);
    step(0, 2, 0, 0, 4'b0000);
    for (int j = 0; j < 30; j++) begin
      step(0, 2, 5, 5, 4'b0001);
      if (j == 0)  pin("t4_fc4", 77, 1, 0);
      if (j == 12) pin("t4_fc16", 642, 0, 0);
      if (j == 27) pin("t4_fc31", 642, 0, 0);
      if (j == 28) pin("t4_fc32", 77, 1, 0);
      step(0, 2, 0, 0, 4'b0000);
    end

    step(0, 2, 100, 50, 4'b0000);
    pin("t2_bg", 8050, 0, 0);
    step(0, 2, 100, 50, 4'b0110);
    pin("t3_pri", 500, 2, 0);
    step(0, 2, 101, 50, 4'b1000);
    pin("t3_l3", 1234, 4, 0);
    step(0, 2, 102, 50, 4'b0111);
    pin("t3_l0", 77, 1, 0);
    step(0, 0, 103, 50, 4'b0110);
    step(0, 0, 0, 0, 4'b0000);
    step(0, 0, 0, 1, 4'b0000);
    step(0, 0, 0, 0, 4'b0000);
    step(0, 0, 100, 50, 4'b0110);
    pin("t3_nospr", 8050, 0, 0);

    step(0, 0, 639, 479, 4'b0001);
    pin("t6_last", 76799, 0, 0);
    step(0, 0, 640, 479, 4'b0000);
    pin("t6_h640", 0, 15, 1);
    step(0, 0, 10, 480, 4'b0000);
    pin("t6_v480", 0, 15, 1);

    // state change, then a second change landing on a frame start
    step(0, 2, 1, 0, 4'b0000);
    step(0, 2, 0, 0, 4'b0000);
    step(0, 2, 2, 0, 4'b0000);
    step(0, 2, 0, 0, 4'b0000);
    step(0, 2, 10, 10, 4'b0000);
    pin("t5_pre", 1605, 0, 0);
    step(0, 4, 11, 10, 4'b0000);
    pin("t5_chg", 0, 15, 1);
    step(0, 4, 0, 0, 4'b0000);
    pin("t5_fs1", 0, 15, 1);
    step(0, 4, 1, 0, 4'b0000);
    step(0, 6, 0, 0, 4'b0000);
    pin("t5_reload", 0, 15, 1);
    step(0, 6, 1, 0, 4'b0000);
    step(0, 6, 0, 0, 4'b0000);
    pin("t5_ext", 0, 15, 1);
    step(0, 6, 2, 0, 4'b0000);
    step(0, 6, 0, 0, 4'b0000);
    pin("t5_show", 0, 0, 0);
    step(0, 6, 4, 2, 4'b0010);
    pin("t5_spr", 500, 2, 0);

    // reset in the middle of a line
    step(0, 6, 300, 200, 4'b0000);
    pin("t6_preRst", 32150, 0, 0);
    step(1, 6, 301, 200, 4'b0000);
    step(0, 6, 302, 200, 4'b0000);
    step(0, 6, 303, 200, 4'b0000);
    pin("t6_postRst", 0, 15, 1);
    step(0, 6, 304, 200, 4'b0000);
    step(0, 6, 305, 200, 4'b0000);
    step(0, 6, 306, 200, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
